// File: rtl/pwm_channel_gen.sv
// PWM channel: prescaled period counter with boundary-latched shadow
// registers, immediate disable, and a registered status word.
module pwm_channel_gen #(
  parameter int unsigned TOP    = 999,
  parameter int unsigned DUTY_W = 12
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DUTY_W+1:0] pwm_ctrl_in,
  input  logic [31:0]       pwm_presc_in,
  output logic [DUTY_W+1:0] pwm_status_out,
  output logic              pwm_out,
  output logic              period_pulse
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic [DUTY_W-1:0] TOP_V = DUTY_W'(TOP);

  logic [31:0]       pre_q, pre_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [31:0]       presc_q, presc_d;
  logic              en_q, en_d;
  logic              inv_q, inv_d;
  logic              tog_q, tog_d;
  logic              pwm_q, pwm_d;
  logic              pulse_q, pulse_d;

  logic go, step;

  assign go   = pwm_ctrl_in[DUTY_W];
  assign step = (pre_q == presc_q);

  always_comb begin
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    presc_d = presc_q;
    en_d    = en_q;
    inv_d   = inv_q;
    tog_d   = tog_q;
    pulse_d = 1'b0;
    pwm_d   = (en_q & (cnt_q < duty_q)) ^ inv_q;
    if (en_q == ST_IDLE) begin
      // Shadows follow the CPU so a start uses the freshest values
      pre_d   = '0;
      cnt_d   = '0;
      duty_d  = pwm_ctrl_in[DUTY_W-1:0];
      inv_d   = pwm_ctrl_in[DUTY_W+1];
      presc_d = pwm_presc_in;
      en_d    = go;
    end else if (!go) begin
      en_d  = 1'b0;
      pre_d = '0;
      cnt_d = '0;
    end else if (step) begin
      pre_d = '0;
      if (cnt_q == TOP_V) begin
        cnt_d   = '0;
        duty_d  = pwm_ctrl_in[DUTY_W-1:0];
        inv_d   = pwm_ctrl_in[DUTY_W+1];
        presc_d = pwm_presc_in;
        tog_d   = ~tog_q;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      pre_d = pre_q + 32'd1;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      presc_q <= '0;
      en_q    <= 1'b0;
      inv_q   <= 1'b0;
      tog_q   <= 1'b0;
      pwm_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      inv_q   <= inv_d;
      tog_q   <= tog_d;
      pwm_q   <= pwm_d;
      pulse_q <= pulse_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign period_pulse   = pulse_q;
  assign pwm_status_out = {tog_q, en_q, duty_q};

endmodule

// File: tb/tb_pwm_channel_gen.sv
// Bench for pwm_channel_gen (TOP=9): directed scenarios plus random
// control traffic against a time-in-period reference model.
module tb_pwm_channel_gen;

  localparam int TOP = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] ctrl = '0;
  logic [31:0] presc = '0;
  logic [13:0] status;
  logic        pwm;
  logic        pulse;

  int tests = 0;
  int fails = 0;

  // reference model: elapsed clocks within the current period
  int m_en, m_duty, m_inv, m_presc, m_tog, m_t;
  int e_pwm, e_pulse;

  pwm_channel_gen #(.TOP(TOP), .DUTY_W(12)) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .pwm_ctrl_in   (ctrl),
    .pwm_presc_in  (presc),
    .pwm_status_out(status),
    .pwm_out       (pwm),
    .period_pulse  (pulse)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_en = 0; m_duty = 0; m_inv = 0; m_presc = 0;
    m_tog = 0; m_t = 0; e_pwm = 0; e_pulse = 0;
  endfunction

  function automatic void model_step();
    int len;
    len = m_presc + 1;
    e_pwm = m_en != 0 ? (((m_t / len) < m_duty) ? 1 : 0) ^ m_inv : m_inv;
    e_pulse = 0;
    if (m_en == 0) begin
      m_duty = int'(ctrl[11:0]);
      m_inv = int'(ctrl[13]);
      m_presc = int'(presc);
      m_en = int'(ctrl[12]);
      m_t = 0;
    end else if (!ctrl[12]) begin
      m_en = 0;
      m_t = 0;
    end else if (m_t == (TOP + 1) * len - 1) begin
      m_t = 0;
      m_duty = int'(ctrl[11:0]);
      m_inv = int'(ctrl[13]);
      m_presc = int'(presc);
      m_tog ^= 1;
      e_pulse = 1;
    end else begin
      m_t++;
    end
  endfunction

  task automatic check();
    logic [13:0] es;
    es = {1'(m_tog), 1'(m_en), 12'(m_duty)};
    tests++;
    assert (pwm === 1'(e_pwm)) else begin
      fails++;
      $error("FAIL pwm_out got %b exp %0d t=%0t", pwm, e_pwm, $time);
    end
    tests++;
    assert (pulse === 1'(e_pulse)) else begin
      fails++;
      $error("FAIL period_pulse got %b exp %0d t=%0t", pulse, e_pulse, $time);
    end
    tests++;
    assert (status === es) else begin
      fails++;
      $error("FAIL status got %h exp %h t=%0t", status, es, $time);
    end
  endtask

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check();
    end
  endtask

  task automatic set(int en, int inv, int duty, int p);
    ctrl = {1'(inv), 1'(en), 12'(duty)};
    presc = 32'(p);
  endtask

  initial begin
    int highs;
    int guard;
    model_reset();
    #1 rst = 1'b1;
    #1;
    tests++;
    assert (pwm === 1'b0 && pulse === 1'b0 && status === 14'h0) else begin
      fails++;
      $error("FAIL reset got pwm=%b pulse=%b st=%h exp 0/0/0", pwm, pulse, status);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // presc 0, duty 3: 3 high / 7 low
    set(1, 0, 3, 0);
    tick(25);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      highs += int'(pwm);
    end
    tests++;
    assert (highs == 3) else begin
      fails++;
      $error("FAIL duty3_highs got %0d exp 3", highs);
    end

    // mid-period duty write at cnt=5
    guard = 0;
    while (m_t != 5 && guard < 50) begin
      tick();
      guard++;
    end
    tests++;
    assert (guard < 50) else begin
      fails++;
      $error("FAIL wait_cnt5 got timeout exp cnt=5");
    end
    set(1, 0, 8, 0);
    tick(30);

    // presc 2, duty 5
    set(1, 0, 5, 2);
    tick(80);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      highs += int'(pwm);
    end
    tests++;
    assert (highs == 15) else begin
      fails++;
      $error("FAIL presc2_highs got %0d exp 15", highs);
    end

    set(1, 0, 0, 0);
    tick(45);
    set(1, 0, 12, 0);
    tick(25);
    set(1, 1, 3, 0);
    tick(25);

    // disable at cnt=2 with inv=1, then re-enable
    guard = 0;
    while (m_t != 2 && guard < 50) begin
      tick();
      guard++;
    end
    set(0, 1, 3, 0);
    tick(6);
    set(1, 1, 3, 0);
    tick(25);

    // random control traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 30) == 0)
        set(($urandom_range(0, 9) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
            int'($urandom_range(0, 12)), int'($urandom_range(0, 3)));
      tick();
    end

    // async reset during the high phase
    set(1, 0, 5, 0);
    tick(3);
    guard = 0;
    while (e_pwm != 1 && guard < 60) begin
      tick();
      guard++;
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    assert (pwm === 1'b0 && status === 14'h0) else begin
      fails++;
      $error("FAIL async_reset got pwm=%b st=%h exp 0/0", pwm, status);
    end
    model_reset();
    set(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
